// File: rtl/ddr_wr_burst_fmt.sv
// Buffers full-width write beats and emits them as fixed-length DDR write bursts.
// Optional DDR_WR_DATA_MASK_EN adds a byte mask carried with every beat.
module ddr_wr_burst_fmt #(
  parameter int DATA_WIDTH   = 64,
  parameter int BURST_LENGTH = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   data_in,
`ifdef DDR_WR_DATA_MASK_EN
  input  logic [DATA_WIDTH/8-1:0] mask_in,
`endif
  input  logic                    din_vd,
  output logic                    din_rdy,
  input  logic                    dout_rdy,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    dout_vd,
  output logic                    dout_first,
  output logic                    dout_last,
  output logic [15:0]             burst_cnt,
`ifdef DDR_WR_DATA_MASK_EN
  output logic [DATA_WIDTH/8-1:0] mask_out,
`endif
  output logic                    ovf_err
);

  localparam int BEATS = BURST_LENGTH / 2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BI_W  = $clog2(BEATS);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BEATS_C   = CNT_W'(BEATS);
  localparam logic [BI_W-1:0]  LAST_BEAT = BI_W'(BEATS - 1);

  // Mask bits, when present, ride in the upper part of each FIFO entry.
`ifdef DDR_WR_DATA_MASK_EN
  localparam int ENTRY_W = DATA_WIDTH + DATA_WIDTH / 8;
  logic [ENTRY_W-1:0] wr_entry;
  assign wr_entry = {mask_in, data_in};
`else
  localparam int ENTRY_W = DATA_WIDTH;
  logic [ENTRY_W-1:0] wr_entry;
  assign wr_entry = data_in;
`endif

  typedef enum logic {IDLE, BURST} state_t;

  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] rd_entry;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  state_t             state;
  logic [BI_W-1:0]    beat_idx;
  logic [BI_W-1:0]    cur_beat;
  logic               push;
  logic               pop;
  logic               launch;
  logic               last_pop;

  assign din_rdy    = (count != DEPTH_C);
  assign push       = din_vd && din_rdy;
  assign launch     = (state == IDLE) && (count >= BEATS_C) && dout_rdy;
  assign pop        = (state == BURST) || launch;
  assign cur_beat   = (state == BURST) ? beat_idx : '0;
  assign last_pop   = pop && (cur_beat == LAST_BEAT);
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign rd_entry   = fifo_mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= wr_entry;
    end
  end

  // A push attempted while full is lost even if a pop frees a slot this cycle.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      if (din_vd && !din_rdy) begin
        ovf_err <= 1'b1;
      end
    end
  end

  // Once launched a burst pops every cycle; dout_rdy only gates the next launch.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state      <= IDLE;
      beat_idx   <= '0;
      data_out   <= '0;
      dout_vd    <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
      burst_cnt  <= '0;
`ifdef DDR_WR_DATA_MASK_EN
      mask_out   <= '0;
`endif
    end else begin
      dout_vd    <= pop;
      dout_first <= pop && (cur_beat == '0);
      dout_last  <= last_pop;
      data_out   <= pop ? rd_entry[DATA_WIDTH-1:0] : '0;
`ifdef DDR_WR_DATA_MASK_EN
      mask_out   <= pop ? rd_entry[ENTRY_W-1:DATA_WIDTH] : '0;
`endif
      if (dout_last) begin
        burst_cnt <= burst_cnt + 16'd1;
      end
      case (state)
        IDLE: begin
          if (launch) begin
            state    <= BURST;
            beat_idx <= BI_W'(1);
          end
        end
        BURST: begin
          if (last_pop) begin
            beat_idx <= '0;
            if (!((count_next >= BEATS_C) && dout_rdy)) begin
              state <= IDLE;
            end
          end else begin
            beat_idx <= beat_idx + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          beat_idx <= '0;
        end
      endcase
    end
  end

endmodule
